// File: rtl/igniter_move_planner_if.sv
// Request handshake between the candle-target queue producer and the move planner.
interface igniter_move_planner_if;
  logic       req_valid;
  logic [2:0] req_target;
  logic       req_ready;

  modport master (output req_valid, output req_target, input req_ready);
  modport slave  (input req_valid, input req_target, output req_ready);
endinterface

// File: rtl/igniter_move_planner.sv
// Queues candle-target requests, walks the igniter there in clamped signed steps,
// then settles and pulses the flame enable for a fixed time.
module igniter_move_planner #(
  parameter int MAX_STEP      = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int IGNITE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          sys_clk,
  input  logic                          clr,
  igniter_move_planner_if.slave         req_if,
  output logic                          enable_move,
  output logic signed [3:0]             delta,
  output logic                          ignite,
  output logic                          done,
  output logic                          busy,
  output logic [2:0]                    pos_shadow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CMAX  = (SETTLE_CYCLES > IGNITE_CYCLES) ? SETTLE_CYCLES : IGNITE_CYCLES;
  localparam int CW    = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] IGNITE_LOAD = CW'(IGNITE_CYCLES - 1);
  localparam logic signed [3:0] MAX_S   = 4'(MAX_STEP);
  localparam logic [AW:0] FULL_COUNT    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE, IGNITE} state_t;

  function automatic logic signed [3:0] clamp_step(input logic signed [3:0] d);
    if (d > MAX_S)       return MAX_S;
    else if (d < -MAX_S) return -MAX_S;
    else                 return d;
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         tgt_q, tgt_d;
  logic [2:0]         pos_shadow_q, pos_shadow_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               enable_move_q, enable_move_d;
  logic signed [3:0]  delta_q, delta_d;
  logic               ignite_q, ignite_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               req_ready_q, req_ready_d;
  logic [AW:0]        count_q, count_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]         fifo_mem [FIFO_DEPTH];

  logic               push, pop;
  logic signed [3:0]  diff_w, step_w;

  always_comb begin
    push = req_if.req_valid & req_ready_q;
    pop  = (state_q == IDLE) && (count_q != '0);

    diff_w = $signed({1'b0, tgt_q}) - $signed({1'b0, pos_shadow_q});
    step_w = clamp_step(diff_w);

    state_d       = state_q;
    tgt_d         = tgt_q;
    pos_shadow_d  = pos_shadow_q;
    cnt_d         = cnt_q;
    enable_move_d = 1'b0;
    delta_d       = '0;
    ignite_d      = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tgt_d   = fifo_mem[rd_ptr_q];
          state_d = MOVE;
        end
      end
      MOVE: begin
        // Clamping toward the target can never overshoot, so the shadow stays in 0..7.
        if (diff_w != '0) begin
          enable_move_d = 1'b1;
          delta_d       = step_w;
          pos_shadow_d  = pos_shadow_q + step_w[2:0];
        end else begin
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          ignite_d = 1'b1;
          cnt_d    = IGNITE_LOAD;
          state_d  = IGNITE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      IGNITE: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ignite_d = 1'b1;
          cnt_d    = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Ready is registered from the next fill level so a full queue never admits a push.
    req_ready_d = (count_d != FULL_COUNT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (clr) begin
      state_q       <= IDLE;
      tgt_q         <= '0;
      pos_shadow_q  <= '0;
      cnt_q         <= '0;
      enable_move_q <= 1'b0;
      delta_q       <= '0;
      ignite_q      <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b1;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      pos_shadow_q  <= pos_shadow_d;
      cnt_q         <= cnt_d;
      enable_move_q <= enable_move_d;
      delta_q       <= delta_d;
      ignite_q      <= ignite_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= req_if.req_target;
  end

  assign req_if.req_ready = req_ready_q;
  assign enable_move      = enable_move_q;
  assign delta            = delta_q;
  assign ignite           = ignite_q;
  assign done             = done_q;
  assign busy             = busy_q;
  assign pos_shadow       = pos_shadow_q;
  assign fifo_count       = count_q;
endmodule

// File: tb/tb_igniter_move_planner.sv
// Directed bench for igniter_move_planner: default build plus a MAX_STEP=7 build.
module tb_igniter_move_planner;
  logic sys_clk = 1'b0;
  logic clr     = 1'b0;
  always #5 sys_clk = ~sys_clk;

  igniter_move_planner_if r_if();
  igniter_move_planner_if r7_if();

  logic              enable_move, ignite, done, busy;
  logic signed [3:0] delta;
  logic [2:0]        pos_shadow;
  logic [2:0]        fifo_count;
  logic              em7, ig7, dn7, busy7;
  logic signed [3:0] d7;
  logic [2:0]        pos7;
  logic [2:0]        cnt7;

  igniter_move_planner dut (
    .sys_clk(sys_clk), .clr(clr), .req_if(r_if),
    .enable_move(enable_move), .delta(delta), .ignite(ignite), .done(done),
    .busy(busy), .pos_shadow(pos_shadow), .fifo_count(fifo_count)
  );

  igniter_move_planner #(.MAX_STEP(7)) dut7 (
    .sys_clk(sys_clk), .clr(clr), .req_if(r7_if),
    .enable_move(em7), .delta(d7), .ignite(ig7), .done(dn7),
    .busy(busy7), .pos_shadow(pos7), .fifo_count(cnt7)
  );

  int vectors = 0;
  int miscompares = 0;

  // Observation word layout: busy_em_delta[3:0]_ignite_done_pos[2:0]
  function automatic logic [10:0] obs();
    return {busy, enable_move, delta, ignite, done, pos_shadow};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_req(input logic [2:0] t);
    r_if.req_valid  = 1'b1;
    r_if.req_target = t;
    tick();
    r_if.req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (obs() !== 11'b0 || fifo_count !== 3'd0 || r_if.req_ready !== 1'b1) begin
        $display("FAIL reset cyc%0d got obs=%b cnt=%0d rdy=%b want obs=0 cnt=0 rdy=1",
                 k, obs(), fifo_count, r_if.req_ready);
        miscompares++;
      end
      vectors++;
      if ({busy7, em7, d7, ig7, dn7, pos7} !== 11'b0 || cnt7 !== 3'd0 || r7_if.req_ready !== 1'b1) begin
        $display("FAIL reset7 cyc%0d got pos=%0d cnt=%0d rdy=%b want 0 0 1", k, pos7, cnt7, r7_if.req_ready);
        miscompares++;
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_single();
    logic [10:0] exp [11];
    exp = '{11'b1_0_0000_0_0_000, 11'b1_1_0011_0_0_011, 11'b1_1_0010_0_0_101,
            11'b1_0_0000_0_0_101, 11'b1_0_0000_0_0_101, 11'b1_0_0000_0_0_101,
            11'b1_0_0000_0_0_101, 11'b1_0_0000_1_0_101, 11'b1_0_0000_1_0_101,
            11'b0_0_0000_0_1_101, 11'b0_0_0000_0_0_101};
    push_req(3'd5);
    vectors++;
    if (fifo_count !== 3'd1 || busy !== 1'b0) begin
      $display("FAIL single_push got cnt=%0d busy=%b want cnt=1 busy=0", fifo_count, busy);
      miscompares++;
    end
    for (int k = 0; k < 11; k++) begin
      tick();
      vectors++;
      if (obs() !== exp[k]) begin
        $display("FAIL single cyc%0d got %b want %b", k + 1, obs(), exp[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_negative();
    logic [10:0] exp [11];
    exp = '{11'b1_0_0000_0_0_101, 11'b1_1_1101_0_0_010, 11'b1_1_1110_0_0_000,
            11'b1_0_0000_0_0_000, 11'b1_0_0000_0_0_000, 11'b1_0_0000_0_0_000,
            11'b1_0_0000_0_0_000, 11'b1_0_0000_1_0_000, 11'b1_0_0000_1_0_000,
            11'b0_0_0000_0_1_000, 11'b0_0_0000_0_0_000};
    push_req(3'd0);
    for (int k = 0; k < 11; k++) begin
      tick();
      vectors++;
      if (obs() !== exp[k]) begin
        $display("FAIL negative cyc%0d got %b want %b", k + 1, obs(), exp[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_move();
    push_req(3'd7);
    tick();
    tick();
    vectors++;
    if (obs() !== 11'b1_1_0011_0_0_011) begin
      $display("FAIL midmove_strobe got %b want %b", obs(), 11'b1_1_0011_0_0_011);
      miscompares++;
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++;
    if (obs() !== 11'b0 || fifo_count !== 3'd0 || r_if.req_ready !== 1'b1) begin
      $display("FAIL midmove_reset got obs=%b cnt=%0d rdy=%b want obs=0 cnt=0 rdy=1",
               obs(), fifo_count, r_if.req_ready);
      miscompares++;
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      vectors++;
      if (obs() !== 11'b0) begin
        $display("FAIL midmove_quiet cyc%0d got %b want 0", k, obs());
        miscompares++;
      end
    end
  endtask

  task automatic test_short_move();
    logic [10:0] exp [10];
    exp = '{11'b1_0_0000_0_0_000, 11'b1_1_0010_0_0_010, 11'b1_0_0000_0_0_010,
            11'b1_0_0000_0_0_010, 11'b1_0_0000_0_0_010, 11'b1_0_0000_0_0_010,
            11'b1_0_0000_1_0_010, 11'b1_0_0000_1_0_010, 11'b0_0_0000_0_1_010,
            11'b0_0_0000_0_0_010};
    push_req(3'd2);
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (obs() !== exp[k]) begin
        $display("FAIL short cyc%0d got %b want %b", k + 1, obs(), exp[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_zero_move();
    logic [10:0] exp [9];
    exp = '{11'b1_0_0000_0_0_010, 11'b1_0_0000_0_0_010, 11'b1_0_0000_0_0_010,
            11'b1_0_0000_0_0_010, 11'b1_0_0000_0_0_010, 11'b1_0_0000_1_0_010,
            11'b1_0_0000_1_0_010, 11'b0_0_0000_0_1_010, 11'b0_0_0000_0_0_010};
    push_req(3'd2);
    for (int k = 0; k < 9; k++) begin
      tick();
      vectors++;
      if (obs() !== exp[k]) begin
        $display("FAIL zero cyc%0d got %b want %b", k + 1, obs(), exp[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] tq [6];
    int idx = 0;
    int ndone = 0;
    bit saw_full = 1'b0;
    bit accepted;
    // First entry is a zero move that keeps the planner busy while the queue fills.
    tq = '{3'd2, 3'd7, 3'd1, 3'd4, 3'd6, 3'd3};
    for (int cyc = 0; cyc < 300 && ndone < 6; cyc++) begin
      if (idx < 6) begin
        r_if.req_valid  = 1'b1;
        r_if.req_target = tq[idx];
      end else begin
        r_if.req_valid = 1'b0;
      end
      accepted = (idx < 6) && (r_if.req_ready === 1'b1);
      tick();
      if (accepted) idx++;
      if (fifo_count == 3'd4) begin
        saw_full = 1'b1;
        vectors++;
        if (r_if.req_ready !== 1'b0) begin
          $display("FAIL bp_ready_full got %b want 0", r_if.req_ready);
          miscompares++;
        end
      end
      if (done === 1'b1) begin
        vectors++;
        if (pos_shadow !== tq[ndone]) begin
          $display("FAIL bp_order done%0d got pos=%0d want %0d", ndone, pos_shadow, tq[ndone]);
          miscompares++;
        end
        ndone++;
      end
    end
    r_if.req_valid = 1'b0;
    vectors++;
    if (ndone != 6 || idx != 6) begin
      $display("FAIL bp_timeout got done=%0d pushed=%0d want 6 6", ndone, idx);
      miscompares++;
    end
    vectors++;
    if (saw_full !== 1'b1) begin
      $display("FAIL bp_fill got full_seen=%b want 1", saw_full);
      miscompares++;
    end
    tick();
    vectors++;
    if (pos_shadow !== 3'd3 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      $display("FAIL bp_final got pos=%0d busy=%b cnt=%0d want 3 0 0", pos_shadow, busy, fifo_count);
      miscompares++;
    end
  endtask

  task automatic test_max_step();
    bit seen_done = 1'b0;
    r7_if.req_valid  = 1'b1;
    r7_if.req_target = 3'd7;
    tick();
    r7_if.req_valid = 1'b0;
    tick();
    vectors++;
    if (busy7 !== 1'b1 || em7 !== 1'b0 || pos7 !== 3'd0) begin
      $display("FAIL max7_pop got busy=%b em=%b pos=%0d want 1 0 0", busy7, em7, pos7);
      miscompares++;
    end
    tick();
    vectors++;
    if (em7 !== 1'b1 || d7 !== 4'b0111 || pos7 !== 3'd7) begin
      $display("FAIL max7_strobe got em=%b delta=%b pos=%0d want 1 0111 7", em7, d7, pos7);
      miscompares++;
    end
    tick();
    vectors++;
    if (em7 !== 1'b0 || d7 !== 4'b0000 || pos7 !== 3'd7) begin
      $display("FAIL max7_single got em=%b delta=%b pos=%0d want 0 0000 7", em7, d7, pos7);
      miscompares++;
    end
    for (int k = 0; k < 20 && !seen_done; k++) begin
      tick();
      if (em7 === 1'b1) begin
        vectors++;
        $display("FAIL max7_extra_strobe got em=1 want 0");
        miscompares++;
      end
      if (dn7 === 1'b1) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b1) begin
      $display("FAIL max7_done got %b want 1", seen_done);
      miscompares++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    r_if.req_valid   = 1'b0;
    r_if.req_target  = 3'd0;
    r7_if.req_valid  = 1'b0;
    r7_if.req_target = 3'd0;
    tick();
    test_reset();
    test_single();
    test_negative();
    test_reset_mid_move();
    test_short_move();
    test_zero_move();
    test_back_to_back();
    test_max_step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
